// File: rtl/cq_pkg.sv
// Shared defaults for the arbitrated circular queue: widths, writer count and
// the width of a requester index (writers 0..NW-1 plus the reader at NW).
package cq_pkg;

  localparam int CQ_DW = 8;
  localparam int CQ_AW = 4;
  localparam int CQ_NW = 4;

  function automatic int idx_w(input int nw);
    return (nw + 1 <= 2) ? 1 : $clog2(nw + 1);
  endfunction

  localparam int CQ_IW = idx_w(CQ_NW);

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: one-hot grant to the first eligible requester at or
// after prio, searching upward with wrap.
module rr_arbiter #(
  parameter int N  = 5,
  parameter int IW = 3
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] prio,
  output logic [N-1:0]  grant
);

  logic          found;
  logic [IW:0]   idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int off = 0; off < N; off++) begin
      idx = {1'b0, prio} + (IW+1)'(off);
      if (idx >= (IW+1)'(N)) idx = idx - (IW+1)'(N);
      // constant inner index keeps the select width-clean
      for (int i = 0; i < N; i++) begin
        if (!found && eligible[i] && idx == (IW+1)'(i)) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cq_arbiter.sv
// Circular queue over an external single-port memory; NW writers and one
// reader share the port through a round-robin arbiter, one access per cycle.
module cq_arbiter
  import cq_pkg::*;
#(
  parameter int DW = CQ_DW,
  parameter int AW = CQ_AW,
  parameter int NW = CQ_NW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NW-1:0]    wr_req,
  input  logic [NW*DW-1:0] wr_data,
  output logic [NW-1:0]    wr_gnt,
  input  logic             rd_req,
  output logic [DW-1:0]    rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_we,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata
);

  localparam int N  = NW + 1;
  localparam int IW = idx_w(NW);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [IW-1:0] prio, gnt_idx;
  logic [N-1:0]  eligible, grant;
  logic [DW-1:0] wdata_sel;
  logic          rd_gnt, any_gnt;

  assign full  = (count == {1'b1, {AW{1'b0}}});
  assign empty = (count == '0);

  // reset masks eligibility so no grant or write strobe escapes a reset cycle
  assign eligible = {rd_req & ~empty & ~rst, wr_req & {NW{~full & ~rst}}};

  rr_arbiter #(.N(N), .IW(IW)) u_rr (
    .eligible (eligible),
    .prio     (prio),
    .grant    (grant)
  );

  always_comb begin
    gnt_idx   = '0;
    wdata_sel = '0;
    for (int i = 0; i < N; i++)
      if (grant[i]) gnt_idx = IW'(i);
    for (int i = 0; i < NW; i++)
      if (grant[i]) wdata_sel = wr_data[i*DW +: DW];
  end

  assign wr_gnt    = grant[NW-1:0];
  assign rd_gnt    = grant[NW];
  assign any_gnt   = |grant;
  assign mem_we    = |wr_gnt;
  assign mem_addr  = mem_we ? wr_ptr : rd_ptr;
  assign mem_wdata = wdata_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      prio     <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_gnt;
      if (any_gnt)
        prio <= (gnt_idx == IW'(NW)) ? '0 : gnt_idx + 1'b1;
      if (mem_we) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= count + 1'b1;
      end else if (rd_gnt) begin
        rd_ptr  <= rd_ptr + 1'b1;
        count   <= count - 1'b1;
        rd_data <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_cq_arbiter.sv
// Bench for cq_arbiter: directed scenarios plus random traffic, all checked
// against a queue-based reference model and a behavioural memory.
module tb_cq_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  wr_req;
  logic [31:0] wr_data;
  logic [3:0]  wr_gnt;
  logic        rd_req;
  logic [7:0]  rd_data;
  logic        rd_valid, full, empty;
  logic [4:0]  count;
  logic [3:0]  mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata, mem_rdata;

  logic [7:0]  mem [16];

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [7:0] q[$];
  int         prio_m, wp, rp;
  logic       exp_rv;
  logic [7:0] exp_rd;

  always #5 clk = ~clk;

  cq_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .wr_req    (wr_req),
    .wr_data   (wr_data),
    .wr_gnt    (wr_gnt),
    .rd_req    (rd_req),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic run_cycle(input logic r, input logic [3:0] wq, input logic rq,
                           input logic [31:0] wd);
    int g, k;
    logic el;
    logic [7:0] d;
    rst = r; wr_req = wq; rd_req = rq; wr_data = wd;
    @(negedge clk);
    g = -1;
    if (!r)
      for (int off = 0; off < 5; off++) begin
        k  = (prio_m + off) % 5;
        el = (k < 4) ? (wq[k] && q.size() < 16) : (rq && q.size() > 0);
        if (g < 0 && el) g = k;
      end
    d = (g >= 0 && g < 4) ? wd[g*8 +: 8] : 8'h00;
    chk("wr_gnt",    wr_gnt,    (g >= 0 && g < 4) ? (32'd1 << g) : 32'd0);
    chk("mem_we",    mem_we,    (g >= 0 && g < 4) ? 32'd1 : 32'd0);
    chk("mem_addr",  mem_addr,  (g >= 0 && g < 4) ? wp : rp);
    chk("mem_wdata", mem_wdata, d);
    chk("count",     count,     q.size());
    chk("full",      full,      q.size() == 16);
    chk("empty",     empty,     q.size() == 0);
    chk("rd_valid",  rd_valid,  exp_rv);
    chk("rd_data",   rd_data,   exp_rd);
    @(posedge clk);
    if (r) begin
      q.delete(); prio_m = 0; wp = 0; rp = 0; exp_rv = 1'b0; exp_rd = 8'h00;
    end else begin
      exp_rv = 1'b0;
      if (g >= 0) begin
        prio_m = (g + 1) % 5;
        if (g < 4) begin
          q.push_back(d); wp = (wp + 1) % 16;
        end else begin
          exp_rd = q.pop_front(); rp = (rp + 1) % 16; exp_rv = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    run_cycle(1'b1, 4'h0, 1'b0, $urandom);
    run_cycle(1'b1, 4'hF, 1'b1, $urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    q.delete(); prio_m = 0; wp = 0; rp = 0; exp_rv = 1'b0; exp_rd = 8'h00;
    rst = 1'b1; wr_req = '0; rd_req = 1'b0; wr_data = '0;
    #1;
    do_reset();

    // writer 2 alone, then all four writers from reset with reader idle
    run_cycle(1'b0, 4'b0100, 1'b0, 32'h00A5_0000);
    run_cycle(1'b0, 4'b0000, 1'b0, $urandom);
    do_reset();
    for (int i = 0; i < 6; i++) run_cycle(1'b0, 4'hF, 1'b0, $urandom);

    // fill to full, extra writes ignored, one read drains 0x00
    do_reset();
    for (int i = 0; i < 16; i++) run_cycle(1'b0, 4'b0001, 1'b0, i);
    run_cycle(1'b0, 4'hF, 1'b0, $urandom);
    run_cycle(1'b0, 4'hF, 1'b0, $urandom);
    run_cycle(1'b0, 4'h0, 1'b1, $urandom);
    run_cycle(1'b0, 4'h0, 1'b0, $urandom);

    // three entries held with prio back at 0, then W0/W1/reader contend
    do_reset();
    run_cycle(1'b0, 4'hF, 1'b0, $urandom);
    run_cycle(1'b0, 4'hF, 1'b0, $urandom);
    run_cycle(1'b0, 4'hF, 1'b0, $urandom);
    run_cycle(1'b0, 4'hF, 1'b0, $urandom);
    run_cycle(1'b0, 4'h0, 1'b1, $urandom);
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 4'b0011, 1'b1, $urandom);

    // alternating write/read across pointer wrap
    do_reset();
    for (int i = 0; i < 20; i++) begin
      run_cycle(1'b0, 4'b0010, 1'b0, $urandom);
      run_cycle(1'b0, 4'b0000, 1'b1, $urandom);
    end
    run_cycle(1'b0, 4'h0, 1'b0, $urandom);

    // reset in the middle of a burst with 7 entries held
    do_reset();
    for (int i = 0; i < 7; i++) run_cycle(1'b0, 4'hF, 1'b0, $urandom);
    run_cycle(1'b1, 4'hF, 1'b1, $urandom);
    run_cycle(1'b0, 4'b1000, 1'b0, $urandom);
    run_cycle(1'b0, 4'h0, 1'b1, $urandom);

    // random traffic with biased request mixes and rare resets
    for (int i = 0; i < 600; i++) begin
      logic [3:0] wq;
      logic       rq;
      wq = 4'($urandom) & ((i % 200 < 100) ? 4'hF : 4'h3) & ((i % 200 >= 150) ? 4'h1 : 4'hF);
      rq = ($urandom_range(0, 99) < ((i % 200 < 100) ? 30 : 70));
      run_cycle(($urandom_range(0, 79) == 0), wq, rq, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
